// File: rtl/rec_pkg.sv
// Shared constants for the truth-table sequencer: FSM encoding, golden table
// default and legal settle-time bounds.
package rec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    localparam logic [3:0] EXPECTED_DEFAULT = 4'b0010;
    localparam int         SETTLE_DEFAULT   = 1;
    localparam int         SETTLE_MIN       = 1;
    localparam int         SETTLE_MAX       = 15;
    localparam int         CNT_W            = 4;

endpackage

// File: rtl/rec_settle_cnt.sv
// Down-counter that times the idle gap between driving a vector and sampling
// the downstream result; done is high once the loaded count has run out.
module rec_settle_cnt
    import rec_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Loading SETTLE-1 makes the SETTLE state last exactly SETTLE cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(SETTLE - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rec_tt_sequencer.sv
// Sweeps all four {a,c} operand pairs through a downstream select stage,
// captures its response and reports it against a golden truth table.
module rec_tt_sequencer
    import rec_pkg::*;
#(
    parameter int         SETTLE   = SETTLE_DEFAULT,
    parameter logic [3:0] EXPECTED = EXPECTED_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s_in,
    output logic       a_out,
    output logic       c_out,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] result,
    output logic       pass,
    output logic [2:0] err_cnt
);

    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("rec_tt_sequencer: SETTLE out of range 1..15");
    end

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] result_q, result_d;
    logic [2:0] err_q, err_d;
    logic       cnt_load;
    logic       cnt_en;
    logic       cnt_done;

    rec_settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .done  (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = 2'd0;
                    result_d = 4'b0000;
                    err_d    = 3'd0;
                end
            end
            ST_DRIVE: begin
                cnt_load = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                result_d[idx_q] = s_in;
                // At most four mismatches per sweep, so the 3-bit count cannot wrap.
                if (s_in != EXPECTED[idx_q]) begin
                    err_d = err_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_REPORT;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            result_q <= 4'b0000;
            err_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Operands are only presented while a vector is in flight; quiet otherwise.
    assign {a_out, c_out} = (state_q == ST_DRIVE || state_q == ST_SETTLE ||
                             state_q == ST_SAMPLE) ? idx_q : 2'b00;
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_REPORT);
    assign result    = result_q;
    assign err_cnt   = err_q;
    assign pass      = (state_q == ST_REPORT) && (err_q == 3'd0);

endmodule

// File: doc/rec_tt_sequencer.md
REC_TT_SEQUENCER -- requirements
Module: rec_tt_sequencer

Interface
REQ-001 Parameter SETTLE, default 1, SHALL set the number of idle cycles between driving a vector and sampling s_in (range 1..15).
REQ-002 Parameter EXPECTED, default 4'b0010, SHALL be the golden truth table: bit {a,c} holds the expected s for that vector.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to run one full truth-table sweep.
REQ-007 s_in  input  1  combinational result from the downstream select stage.
REQ-008 a_out  output  1  selector operand driven to the downstream stage.
REQ-009 c_out  output  1  data operand driven to the downstream stage.
REQ-010 busy  output  1  high from sweep launch until the report is accepted.
REQ-011 res_valid  output  1  report available.
REQ-012 res_ready  input  1  consumer accepts the report.
REQ-013 result  output  4  captured s per vector, bit index {a,c}.
REQ-014 pass  output  1  result == EXPECTED, valid while res_valid is high.
REQ-015 err_cnt  output  3  number of mismatching bits in result (0..4).

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, REPORT.
REQ-017 IDLE: start=1 -> DRIVE next cycle; vector index cleared to 0, result cleared to 0, busy=1 from that cycle.
REQ-018 DRIVE: {a_out,c_out} = index for one cycle, then -> SETTLE.
REQ-019 SETTLE: operands held; counter counts SETTLE cycles, then -> SAMPLE.
REQ-020 SAMPLE: result[index] <= s_in; err_cnt increments if s_in != EXPECTED[index]; index 3 -> REPORT, else index+1 -> DRIVE.
REQ-021 a_out/c_out SHALL stay stable from DRIVE through SAMPLE of the same vector; in IDLE and REPORT they SHALL be 0.
REQ-022 Sweep latency, start to first res_valid = 4*(SETTLE+2)+1 cycles (13 for SETTLE=1).
REQ-023 REPORT: res_valid=1; result, pass, err_cnt held stable until res_valid && res_ready.
REQ-024 Handshake fires -> IDLE next cycle, res_valid=0, busy=0; result/err_cnt retain last value until next start.
REQ-025 res_ready low SHALL stall REPORT indefinitely with no output change.
REQ-026 start while busy (any non-IDLE state, including the accept cycle) SHALL be ignored, not queued.
REQ-027 res_ready outside REPORT SHALL have no effect.
REQ-028 err_cnt SHALL never wrap (max 4 fits 3 bits); pass = (err_cnt == 0) in REPORT, 0 elsewhere.
REQ-029 Index SHALL be 2 bits; the 3->0 wrap never occurs inside a sweep (REPORT intercepts).

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, index=0, settle counter=0, a_out=0, c_out=0, busy=0, res_valid=0, result=0, pass=0, err_cnt=0.
REQ-031 reset SHALL override start, res_ready and any in-progress sweep (mid-sweep reset discards partial results).
REQ-032 First start honoured is the one on the cycle after reset deasserts.

Structure
REQ-033 State encoding constants, EXPECTED default and SETTLE bounds SHALL live in shared package rec_pkg.
REQ-034 The settle counter SHALL be sub-module rec_settle_cnt (load, count-done output); all else in one module.
REQ-035 Bench SHALL connect the existing a/c/s select stage as the s_in source.

Verification
REQ-036 Good DUT, SETTLE=1, start pulse -> res_valid at cycle 13, result=4'b0010, pass=1, err_cnt=0.
REQ-037 s_in forced 1 -> result=4'b1111, pass=0, err_cnt=3.
REQ-038 res_ready held low 10 cycles in REPORT -> outputs unchanged, busy=1; ready high -> IDLE next cycle, busy=0.
REQ-039 start re-pulsed during SETTLE of vector 2 -> ignored, single report produced, latency unchanged.
REQ-040 reset asserted during vector 2 SAMPLE -> next cycle all outputs 0, IDLE; fresh start completes normally.
REQ-041 SETTLE=3 -> a_out/c_out stable 5 cycles per vector, res_valid at cycle 21.
